// File: rtl/player_instr_arb.sv
// ---------------------------------------------------------------------------
// player_instr_arb
//
// Arbitrates four player-command requesters (set-HP, heal, damage, move) onto
// one 16-bit instruction channel for the player datapath. At most one request
// is granted per IDLE cycle. The granted instruction is held in HOLD until
// the datapath takes it. A gap counter spaces consecutive MOV instructions.
//
// Instruction word: {op[3:0], operand[7:0], 4'b0000}
//
// Ports
//   clk                                clock, all state on posedge
//   rst_n                              asynchronous active-low reset
//   flush                              synchronous clear (page change)
//   shp_valid / shp_ready / shp_val    set-HP requester (payload 8 bit)
//   heal_valid / heal_ready / heal_amt heal requester
//   dmg_valid / dmg_ready / dmg_amt    damage requester
//   mov_valid / mov_ready / mov_dir    move requester
//   instr / instr_valid / instr_ready  instruction channel to the datapath
//   busy                               high while an instruction is held
// ---------------------------------------------------------------------------
module player_instr_arb #(
   parameter int unsigned MOV_GAP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        shp_valid,
   output logic        shp_ready,
   input  logic [7:0]  shp_val,
   input  logic        heal_valid,
   output logic        heal_ready,
   input  logic [7:0]  heal_amt,
   input  logic        dmg_valid,
   output logic        dmg_ready,
   input  logic [7:0]  dmg_amt,
   input  logic        mov_valid,
   output logic        mov_ready,
   input  logic [7:0]  mov_dir,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        busy
);

   localparam logic [3:0] OP_HPY = 4'b0001;
   localparam logic [3:0] OP_DPY = 4'b0010;
   localparam logic [3:0] OP_MOV = 4'b0101;
   localparam logic [3:0] OP_SHP = 4'b0110;

   // Requester index order: 0 shp, 1 heal, 2 dmg, 3 mov
   localparam logic [15:0] REQ_OPS  = {OP_MOV, OP_DPY, OP_HPY, OP_SHP};
   localparam logic [3:0]  GAP_LOAD = 4'(MOV_GAP);

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] instr_reg, instr_next;
   logic [3:0]  gap_reg, gap_next;
   logic        last_dpy_reg, last_dpy_next;   // 0: heal won last tie-group grant

   logic [3:0]  grant;
   logic [7:0]  req_payload [4];
   logic [15:0] req_word    [4];
   logic [15:0] req_masked  [4];
   logic [15:0] grant_word;
   logic        dmg_zero;

   assign req_payload[0] = shp_val;
   assign req_payload[1] = heal_amt;
   assign req_payload[2] = dmg_amt;
   assign req_payload[3] = mov_dir;

   // Per-requester candidate instruction, masked by the one-hot grant so the
   // selected word can be formed with a plain OR.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_req
         assign req_word[gi]   = {REQ_OPS[gi*4 +: 4], req_payload[gi], 4'b0000};
         assign req_masked[gi] = grant[gi] ? req_word[gi] : 16'h0000;
      end
   endgenerate

   assign grant_word = req_masked[0] | req_masked[1] | req_masked[2] | req_masked[3];

   // Grant selection: only in IDLE and never in a flush cycle.
   always_comb begin
      grant = 4'b0000;
      if (state_reg == ST_IDLE && !flush) begin
         if (shp_valid) begin
            grant[0] = 1'b1;
         end else if (heal_valid && dmg_valid) begin
            // Tie: give it to whichever of the pair did not win last time.
            if (last_dpy_reg) grant[1] = 1'b1;
            else              grant[2] = 1'b1;
         end else if (heal_valid) begin
            grant[1] = 1'b1;
         end else if (dmg_valid) begin
            grant[2] = 1'b1;
         end else if (mov_valid && gap_reg == 4'd0) begin
            grant[3] = 1'b1;
         end
      end
   end

   // Readies are gated with rst_n so they drop the instant reset asserts,
   // even though the requesters may still be presenting valid.
   assign shp_ready  = grant[0] & rst_n;
   assign heal_ready = grant[1] & rst_n;
   assign dmg_ready  = grant[2] & rst_n;
   assign mov_ready  = grant[3] & rst_n;

   // A zero-damage request is consumed without producing an instruction.
   assign dmg_zero = grant[2] && (dmg_amt == 8'd0);

   always_comb begin
      state_next    = state_reg;
      instr_next    = instr_reg;
      last_dpy_next = last_dpy_reg;
      gap_next      = (gap_reg != 4'd0) ? gap_reg - 4'd1 : 4'd0;

      if (flush) begin
         state_next = ST_IDLE;
         instr_next = 16'h0000;
         gap_next   = 4'd0;
      end else if (state_reg == ST_HOLD) begin
         if (instr_ready) begin
            state_next = ST_IDLE;
            // Spacing starts from the moment the MOV leaves the arbiter.
            if (instr_reg[15:12] == OP_MOV) gap_next = GAP_LOAD;
         end
      end else if (grant != 4'b0000) begin
         if (grant[1]) last_dpy_next = 1'b0;
         if (grant[2]) last_dpy_next = 1'b1;
         if (!dmg_zero) begin
            state_next = ST_HOLD;
            instr_next = grant_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         instr_reg    <= 16'h0000;
         gap_reg      <= 4'd0;
         last_dpy_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         instr_reg    <= instr_next;
         gap_reg      <= gap_next;
         last_dpy_reg <= last_dpy_next;
      end
   end

   assign instr       = instr_reg;
   assign instr_valid = (state_reg == ST_HOLD);
   assign busy        = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_player_instr_arb.sv
// ---------------------------------------------------------------------------
// tb_player_instr_arb
//
// Directed scenarios for the arbiter's key behaviours followed by randomized
// traffic. A behavioural model of the arbiter runs alongside the DUT and
// predicts readies, instr_valid, busy and instr every cycle.
// ---------------------------------------------------------------------------
module tb_player_instr_arb;

   localparam int GAP = 4;

   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        shp_valid, heal_valid, dmg_valid, mov_valid;
   logic        shp_ready, heal_ready, dmg_ready, mov_ready;
   logic [7:0]  shp_val, heal_amt, dmg_amt, mov_dir;
   logic [15:0] instr;
   logic        instr_valid, instr_ready, busy;

   player_instr_arb #(.MOV_GAP(GAP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .shp_valid   (shp_valid),
      .shp_ready   (shp_ready),
      .shp_val     (shp_val),
      .heal_valid  (heal_valid),
      .heal_ready  (heal_ready),
      .heal_amt    (heal_amt),
      .dmg_valid   (dmg_valid),
      .dmg_ready   (dmg_ready),
      .dmg_amt     (dmg_amt),
      .mov_valid   (mov_valid),
      .mov_ready   (mov_ready),
      .mov_dir     (mov_dir),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_pending;       // an instruction is waiting for the datapath
   logic [15:0] m_word;
   bit          m_word_known;    // instr value is defined (after reset/flush/grant)
   int          m_gap;
   bit          m_heal_last;     // heal was the most recent heal/dmg winner
   logic [3:0]  last_g;          // model grant of the last cycle {mov,dmg,heal,shp}
   int          cyc = 0;
   bit          prev_iv = 0;
   int          rises[$];

   function automatic logic [15:0] word_of(input logic [3:0] op, input logic [7:0] v);
      return (16'(op) << 12) | (16'(v) << 4);
   endfunction

   function automatic logic [3:0] model_grant();
      if (m_pending || flush || !rst_n) return 4'b0000;
      if (shp_valid) return 4'b0001;
      if (heal_valid && dmg_valid) return m_heal_last ? 4'b0100 : 4'b0010;
      if (heal_valid) return 4'b0010;
      if (dmg_valid)  return 4'b0100;
      if (mov_valid && m_gap == 0) return 4'b1000;
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_pending = 0; m_word = 16'h0; m_word_known = 1; m_gap = 0; m_heal_last = 1;
      last_g = 4'b0000;
   endtask

   // One clock cycle: inputs already applied; check at negedge, advance model,
   // return 1 time unit after the posedge.
   task automatic cycle();
      logic [3:0] g;
      int         new_gap;
      @(negedge clk);
      g = model_grant();
      check("ready", {12'h0, mov_ready, dmg_ready, heal_ready, shp_ready}, {12'h0, g});
      check("instr_valid", {15'h0, instr_valid}, {15'h0, m_pending});
      check("busy", {15'h0, busy}, {15'h0, m_pending});
      if (m_word_known) check("instr", instr, m_word);
      if (instr_valid && !prev_iv) rises.push_back(cyc);
      prev_iv = instr_valid;

      new_gap = (m_gap > 0) ? m_gap - 1 : 0;
      if (flush) begin
         m_pending = 0; m_word = 16'h0; m_word_known = 1; new_gap = 0;
      end else if (m_pending) begin
         if (instr_ready) begin
            if (m_word[15:12] == 4'b0101) new_gap = GAP;
            m_pending = 0; m_word_known = 0;
         end
      end else if (g != 0) begin
         if (g[1]) m_heal_last = 1;
         if (g[2]) m_heal_last = 0;
         m_pending = 1; m_word_known = 1;
         if (g[0]) m_word = word_of(4'b0110, shp_val);
         if (g[1]) m_word = word_of(4'b0001, heal_amt);
         if (g[2]) m_word = word_of(4'b0010, dmg_amt);
         if (g[3]) m_word = word_of(4'b0101, mov_dir);
         if (g[2] && dmg_amt == 0) begin
            m_pending = 0; m_word_known = 1;
            m_word = instr_known_hold(m_word);
         end
      end
      m_gap  = new_gap;
      last_g = g;
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d grant=%b instr=%h valid=%0b", cyc, g, instr, instr_valid);
   endtask

   // Zero-damage leaves the previously held word untouched; remember it.
   logic [15:0] held_word;
   function automatic logic [15:0] instr_known_hold(input logic [15:0] unused_w);
      return held_word;
   endfunction

   task automatic drop_granted();
      if (last_g[0]) shp_valid  = 0;
      if (last_g[1]) heal_valid = 0;
      if (last_g[2]) dmg_valid  = 0;
      if (last_g[3]) mov_valid  = 0;
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         drop_granted();
         cycle();
      end
   endtask

   // Track the register value the DUT should keep across a zero-damage grant.
   always @(posedge clk) held_word <= m_word_known ? m_word : held_word;

   initial begin
      rst_n = 0; flush = 0; instr_ready = 0;
      shp_valid = 0; heal_valid = 0; dmg_valid = 0; mov_valid = 0;
      shp_val = 0; heal_amt = 0; dmg_amt = 0; mov_dir = 0;
      held_word = 16'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", instr, 16'h0000);
      check("rst_outs", {12'h0, instr_valid, busy, shp_ready, mov_ready}, 16'h0);
      rst_n = 1;

      // Single SHP
      shp_valid = 1; shp_val = 8'd100; instr_ready = 1;
      cycle();
      check("shp_instr", instr, 16'h6640);
      check("shp_valid", {15'h0, instr_valid}, 16'h1);
      drop_granted();
      cycle();
      check("shp_idle", {15'h0, busy}, 16'h0);

      // Heal/damage tie, twice
      for (int t = 0; t < 2; t++) begin
         heal_valid = 1; heal_amt = 8'd10; dmg_valid = 1; dmg_amt = 8'd7;
         cycle();
         check("tie_first_dpy", instr, 16'h2070);
         drop_granted(); cycle();
         cycle();
         check("tie_second_hpy", instr, 16'h10A0);
         drop_granted(); cycle();
      end

      // MOV spacing
      rises.delete();
      mov_valid = 1; mov_dir = 8'd3; instr_ready = 1;
      repeat (20) cycle();
      check("mov_rises", 16'(rises.size() >= 3), 16'h1);
      for (int k = 0; k + 1 < rises.size(); k++)
         check("mov_spacing", 16'(rises[k+1] - rises[k]), 16'd6);
      mov_valid = 0;
      run_idle(8);

      // Stall with dmg 5, heal waiting behind it
      dmg_valid = 1; dmg_amt = 8'd5; instr_ready = 0;
      cycle();
      drop_granted();
      heal_valid = 1; heal_amt = 8'd9;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("stall_instr", instr, 16'h2050);
      end
      instr_ready = 1;
      cycle();
      check("stall_accept", {15'h0, instr_valid}, 16'h0);
      run_idle(4);

      // Flush while a MOV is accepted
      run_idle(6);
      mov_valid = 1; mov_dir = 8'd1; instr_ready = 0;
      cycle();
      flush = 1; instr_ready = 1;
      cycle();
      flush = 0;
      check("flush_instr", instr, 16'h0000);
      check("flush_valid", {15'h0, instr_valid}, 16'h0);
      instr_ready = 0;
      cycle();
      check("flush_mov_regrant", instr, 16'h5010);

      // Asynchronous reset in HOLD
      mov_valid = 0; shp_valid = 1; shp_val = 8'h21;
      #2 rst_n = 0;
      #1;
      check("arst_outs", {11'h0, instr_valid, busy, shp_ready, heal_ready | dmg_ready, mov_ready}, 16'h0);
      check("arst_instr", instr, 16'h0000);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      cycle();
      check("first_grant", instr, 16'h6210);
      instr_ready = 1; drop_granted();
      cycle();

      // Zero damage
      dmg_valid = 1; dmg_amt = 8'd0;
      cycle();
      check("zero_dmg_valid", {14'h0, instr_valid, busy}, 16'h0);
      drop_granted();
      heal_valid = 1; heal_amt = 8'd2; dmg_valid = 1; dmg_amt = 8'd3;
      cycle();
      check("zero_dmg_rr", instr, 16'h1020);
      run_idle(6);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if (last_g[0] || !shp_valid)  begin shp_valid  = ($urandom_range(0, 9) == 0); shp_val  = 8'($urandom); end
         if (last_g[1] || !heal_valid) begin heal_valid = ($urandom_range(0, 3) == 0); heal_amt = 8'($urandom); end
         if (last_g[2] || !dmg_valid)  begin
            dmg_valid = ($urandom_range(0, 3) == 0);
            dmg_amt   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
         end
         if (last_g[3] || !mov_valid)  begin mov_valid  = ($urandom_range(0, 1) == 0); mov_dir  = 8'($urandom_range(0, 3)); end
         instr_ready = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 29) == 0);
         cycle();
      end
      flush = 0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
